// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package round_robin_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_N        = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 16;

    // Index width that stays at least one bit wide.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface round_robin_arbiter_if
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
);
    localparam int unsigned IW = idx_width(N);

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );
endinterface

// File: rtl/round_robin_arbiter_rr_priority_pick.sv
// Combinational rotating-priority search: first set request at or above the pointer.
module rr_priority_pick
    import round_robin_arbiter_pkg::*;
#(
    parameter  int unsigned N  = DEFAULT_N,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid_c,
    output logic [IW-1:0] o_winner_c
);

    int unsigned w_cand;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        o_valid_c  = 1'b0;
        o_winner_c = '0;
        w_cand     = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_cand = (32'(i_ptr) + 32'(k)) % N;
            if (i_req[IW'(w_cand)]) begin
                o_valid_c  = 1'b1;
                o_winner_c = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a hold limit; one idle cycle always separates grants.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                  clock,
    input  logic                  reset,
    round_robin_arbiter_if.slave  bus
);

    localparam int unsigned   IW         = idx_width(N);
    localparam int unsigned   CW         = idx_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

    state_t        r_state,   w_state_nxt;
    logic [N-1:0]  r_gnt,     w_gnt_nxt;
    logic [IW-1:0] r_gnt_id,  w_gnt_id_nxt;
    logic          r_busy,    w_busy_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [IW-1:0] r_ptr,     w_ptr_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;

    logic          w_pick_valid;
    logic [IW-1:0] w_pick_winner;
    logic          w_limit;
    logic          w_owner_req;

    rr_priority_pick #(.N(N)) u_pick (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_valid_c  (w_pick_valid),
        .o_winner_c (w_pick_winner)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next state and next registered outputs; gnt_id and ptr hold unless a grant is issued.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_limit       = (r_cnt == HOLD_LIMIT);
        w_owner_req   = bus.req[r_gnt_id];

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = N'(1) << w_pick_winner;
                    w_gnt_id_nxt = w_pick_winner;
                    w_busy_nxt   = 1'b1;
                    w_ptr_nxt    = (w_pick_winner == IW'(N - 1)) ? '0 : w_pick_winner + IW'(1);
                    w_cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (bus.done || !w_owner_req || w_limit) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    // Only a pure limit expiry is a timeout; a coincident release wins.
                    w_timeout_nxt = w_limit && !bus.done && w_owner_req;
                end else if (!w_limit) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 16, maximum cycles a grant is held before forced release (>=2).
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  N  per-requester request level; bit i = requester i.
REQ-006 Port done  input  1  owner releases the resource this cycle.
REQ-007 Port gnt  output  N  one-hot grant, registered.
REQ-008 Port gnt_id  output  clog2(N)  index of the granted requester, registered.
REQ-009 Port busy  output  1  high while any grant is active.
REQ-010 Port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 IDLE: if req is nonzero, SHALL pick a winner, assert gnt[winner] and gnt_id=winner, set busy=1, and enter GRANT on the next edge; otherwise stay IDLE.
REQ-013 Winner SHALL be the first set req bit searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-014 On every grant, ptr SHALL load (winner+1) mod N; ptr SHALL not change otherwise.
REQ-015 Grant latency SHALL be one cycle: req sampled high in IDLE at edge k gives gnt high after edge k+1.
REQ-016 GRANT SHALL end on the first cycle in which done=1 or req[gnt_id]=0 (release) or the hold counter equals MAX_HOLD-1 (timeout).
REQ-017 On release or timeout, gnt SHALL be 0, busy 0, and the state IDLE after the next edge; gnt_id SHALL keep its last value.
REQ-018 Exactly one IDLE cycle SHALL separate consecutive grants; gnt SHALL never switch directly between two requesters.
REQ-019 The hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and saturate at MAX_HOLD-1.
REQ-020 timeout SHALL pulse for exactly one cycle, aligned with gnt falling, only when the counter limit ends the grant and done=0 and req[gnt_id]=1.
REQ-021 If done and the counter limit coincide, the end SHALL be treated as a release, with timeout=0.
REQ-022 req changes of non-owners during GRANT SHALL be ignored.
REQ-023 done asserted in IDLE SHALL be ignored.
REQ-024 gnt SHALL be one-hot or zero in every cycle; busy SHALL equal |gnt.

Reset
REQ-025 While reset=1 at an edge: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, counter=0.
REQ-026 Reset asserted during GRANT SHALL drop gnt after that edge, with no timeout pulse.
REQ-027 Reset SHALL override all other inputs; the first grant after reset SHALL favour requester 0.

Structure
REQ-028 A shared package SHALL hold the state enum {IDLE, GRANT} and the default values of N and MAX_HOLD.
REQ-029 Winner selection SHALL be a combinational sub-module rr_priority_pick (inputs req, ptr; outputs valid, winner index).
REQ-030 All outputs SHALL be driven by flops; there SHALL be no combinational path from input to output.

Verification
REQ-031 Reset, then req=4'b1111 held, each grant released by a one-cycle done -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-032 req=4'b0100 at edge k after reset -> gnt=4'b0100 and gnt_id=2 after edge k+1; next search starts at 3.
REQ-033 Requester 1 holds req with no done, MAX_HOLD=16 -> gnt held 16 cycles, timeout pulses once as gnt falls, then requester 1 is re-granted after one IDLE cycle if it is alone.
REQ-034 done and counter limit in the same cycle -> release with timeout=0.
REQ-035 Reset asserted mid-GRANT with req=4'b1010 -> gnt=0 after the edge; after reset is released, requester 1 wins first.
REQ-036 Owner drops req while others request -> gnt clears next cycle; the next requester in ptr order wins after one IDLE cycle; one-hot assertion holds throughout.
